// File: rtl/mem_load_store_unit.sv
`timescale 1ns/1ps
// mem_load_store_unit
// Bridges the core's execute/memory stage to a memory-mapped peripheral
// port. It takes one load/store at a time, issues a single-cycle request,
// waits a bounded number of cycles for the registered response, and returns
// extended load data plus an error flag and code.
//
// Handshake: an operation is accepted on a rising clk edge where
// i_valid && o_ready. i_valid while o_ready is low is ignored and nothing is
// queued. o_done pulses for one cycle; o_rd_data/o_err/o_err_code are valid
// then and hold until the next completion.
//
// Ports:
//   clk, aresetn                  clock, asynchronous active-low reset
//   i_valid / o_ready             core operation handshake
//   i_addr, i_wr_data, i_wr_en    byte address, right-justified store data, 1=store
//   i_count, i_unsigned           access size, zero-extend loads when 1
//   o_req_addr, o_req_wr_data     peripheral request address / write data
//   o_req_wr_en, o_req_count      peripheral write enable / size (NONE when idle)
//   i_res_rd_data, i_res_code     peripheral response data / code
//   o_done, o_rd_data             completion pulse, extended load result
//   o_err, o_err_code             failure flag, failing code (INVALID on timeout)
//   o_dbg_state                   current FSM state (IDLE=0 REQ=1 WAIT=2 DONE=3)

`ifndef MEM_COUNT_W
`define MEM_COUNT_W          2
`define MEM_COUNT_NONE       2'd0
`define MEM_COUNT_BYTE       2'd1
`define MEM_COUNT_HALF       2'd2
`define MEM_COUNT_WORD       2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W           3
`define MEM_CODE_INVALID     3'd0
`define MEM_CODE_READ        3'd1
`define MEM_CODE_WRITE       3'd2
`define MEM_CODE_MISALIGNED  3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module mem_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [WORD_W-1:0]      i_wr_data,
    input  logic                   i_wr_en,
    input  logic [`MEM_COUNT_W-1:0] i_count,
    input  logic                   i_unsigned,
    output logic [ADDR_W-1:0]      o_req_addr,
    output logic [WORD_W-1:0]      o_req_wr_data,
    output logic                   o_req_wr_en,
    output logic [`MEM_COUNT_W-1:0] o_req_count,
    input  logic [WORD_W-1:0]      i_res_rd_data,
    input  logic [`MEM_CODE_W-1:0] i_res_code,
    output logic                   o_done,
    output logic [WORD_W-1:0]      o_rd_data,
    output logic                   o_err,
    output logic [`MEM_CODE_W-1:0] o_err_code,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0]       addr_q;
    logic [WORD_W-1:0]       wr_data_q;
    logic                    wr_en_q;
    logic [`MEM_COUNT_W-1:0] count_q;
    logic                    unsigned_q;
    logic [7:0]              cnt_q;
    logic                    ready_q;
    logic [WORD_W-1:0]       rd_data_q;
    logic                    err_q;
    logic [`MEM_CODE_W-1:0]  err_code_q;

    logic                    accept;
    logic                    res_seen;
    logic                    timed_out;
    logic [WORD_W-1:0]       res_rd_data;
    logic                    res_err;

    assign accept    = (state == S_IDLE) && ready_q && i_valid;
    assign res_seen  = (i_res_code != `MEM_CODE_INVALID);
    assign timed_out = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept)
                        next_state = (i_count == `MEM_COUNT_NONE) ? S_DONE : S_REQ;
            S_REQ:  next_state = S_WAIT;
            S_WAIT: if (res_seen || timed_out) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state. The request only carries a size while in
    // REQ, so the peripheral sees exactly one request cycle.
    always_comb begin
        o_req_count = `MEM_COUNT_NONE;
        o_req_wr_en = 1'b0;
        o_done      = 1'b0;
        case (state)
            S_REQ: begin
                o_req_count = count_q;
                o_req_wr_en = wr_en_q;
            end
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_req_addr    = addr_q;
    assign o_req_wr_data = wr_data_q;
    assign o_ready       = ready_q;
    assign o_rd_data     = rd_data_q;
    assign o_err         = err_q;
    assign o_err_code    = err_code_q;
    assign o_dbg_state   = state;

    // Response classification: success only when the code matches the
    // direction of the operation; every other code is reported as an error.
    always_comb begin
        res_rd_data = '0;
        res_err     = 1'b1;
        if (!wr_en_q && i_res_code == `MEM_CODE_READ) begin
            res_err = 1'b0;
            case (count_q)
                `MEM_COUNT_BYTE: res_rd_data = {{(WORD_W-8){i_res_rd_data[7] & ~unsigned_q}},
                                                i_res_rd_data[7:0]};
                `MEM_COUNT_HALF: res_rd_data = {{(WORD_W-16){i_res_rd_data[15] & ~unsigned_q}},
                                                i_res_rd_data[15:0]};
                default:         res_rd_data = i_res_rd_data;
            endcase
        end else if (wr_en_q && i_res_code == `MEM_CODE_WRITE) begin
            res_err = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q     <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            count_q    <= `MEM_COUNT_NONE;
            unsigned_q <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= `MEM_CODE_INVALID;
        end else begin
            // Registered copy of "next state is IDLE", so o_ready comes up
            // one cycle after reset release and tracks IDLE afterwards.
            ready_q <= (next_state == S_IDLE);
            case (state)
                S_IDLE: if (accept) begin
                    addr_q     <= i_addr;
                    wr_data_q  <= i_wr_data;
                    wr_en_q    <= i_wr_en;
                    count_q    <= i_count;
                    unsigned_q <= i_unsigned;
                    if (i_count == `MEM_COUNT_NONE) begin
                        rd_data_q  <= '0;
                        err_q      <= 1'b1;
                        err_code_q <= `MEM_CODE_INVALID;
                    end
                end
                S_REQ: cnt_q <= '0;
                S_WAIT: begin
                    if (res_seen) begin
                        rd_data_q  <= res_rd_data;
                        err_q      <= res_err;
                        err_code_q <= i_res_code;
                    end else if (timed_out) begin
                        rd_data_q  <= '0;
                        err_q      <= 1'b1;
                        err_code_q <= `MEM_CODE_INVALID;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_store_unit.sv
`timescale 1ns/1ps
`ifndef MEM_COUNT_W
`define MEM_COUNT_W          2
`define MEM_COUNT_NONE       2'd0
`define MEM_COUNT_BYTE       2'd1
`define MEM_COUNT_HALF       2'd2
`define MEM_COUNT_WORD       2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W           3
`define MEM_CODE_INVALID     3'd0
`define MEM_CODE_READ        3'd1
`define MEM_CODE_WRITE       3'd2
`define MEM_CODE_MISALIGNED  3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module tb_mem_load_store_unit;

    localparam int T = 8;

    // Clock / reset
    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic        i_wr_en = 1'b0;
    logic [1:0]  i_count = '0;
    logic        i_unsigned = 1'b0;
    logic [31:0] o_req_addr;
    logic [31:0] o_req_wr_data;
    logic        o_req_wr_en;
    logic [1:0]  o_req_count;
    logic [31:0] i_res_rd_data = '0;
    logic [2:0]  i_res_code = '0;
    logic        o_done;
    logic [31:0] o_rd_data;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic [1:0]  o_dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    mem_load_store_unit #(.TIMEOUT_CYCLES(T), .ADDR_W(32), .WORD_W(32)) dut (
        .clk(clk), .aresetn(aresetn),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_wr_data(i_wr_data), .i_wr_en(i_wr_en),
        .i_count(i_count), .i_unsigned(i_unsigned),
        .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
        .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count),
        .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code),
        .o_done(o_done), .o_rd_data(o_rd_data),
        .o_err(o_err), .o_err_code(o_err_code),
        .o_dbg_state(o_dbg_state)
    );

    // Advance one cycle and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full operation from accept (cycle 0) through the IDLE after DONE.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic wr, input logic [1:0] cnt, input logic uns,
                         input logic [2:0] rcode, input logic [31:0] rdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [2:0] exp_code);
        chk({tag, ":ready0"}, o_ready, 1);
        i_valid = 1'b1; i_addr = a; i_wr_data = wd; i_wr_en = wr;
        i_count = cnt; i_unsigned = uns;
        step();
        i_valid = 1'b0;
        // cycle 1: request
        chk({tag, ":req_count"}, o_req_count, cnt);
        chk({tag, ":req_wr_en"}, o_req_wr_en, wr);
        chk({tag, ":req_addr"}, o_req_addr, a);
        chk({tag, ":ready1"}, o_ready, 0);
        if (wr) chk({tag, ":req_wr_data"}, o_req_wr_data, wd);
        step();
        // cycle 2: waiting, response arrives
        chk({tag, ":wait_count"}, o_req_count, `MEM_COUNT_NONE);
        chk({tag, ":wait_wr_en"}, o_req_wr_en, 0);
        chk({tag, ":wait_done"}, o_done, 0);
        i_res_code = rcode; i_res_rd_data = rdata;
        step();
        // cycle 3: done
        i_res_code = `MEM_CODE_INVALID; i_res_rd_data = 32'h5A5A_A5A5;
        chk({tag, ":done"}, o_done, 1);
        chk({tag, ":rd_data"}, o_rd_data, exp_rd);
        chk({tag, ":err"}, o_err, exp_err);
        chk({tag, ":err_code"}, o_err_code, exp_code);
        step();
        // cycle 4: idle again, result held
        chk({tag, ":done_low"}, o_done, 0);
        chk({tag, ":ready4"}, o_ready, 1);
        chk({tag, ":hold_rd"}, o_rd_data, exp_rd);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst:ready", o_ready, 0);
        chk("rst:req_count", o_req_count, `MEM_COUNT_NONE);
        chk("rst:done", o_done, 0);
        chk("rst:err", o_err, 0);
        chk("rst:err_code", o_err_code, `MEM_CODE_INVALID);
        chk("rst:rd_data", o_rd_data, 0);
        chk("rst:state", o_dbg_state, 0);
        aresetn = 1'b1;
        step();
        chk("rst:ready_after", o_ready, 1);

        // Signed byte load
        do_op("ld_b_s", 32'h1001, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b0,
              `MEM_CODE_READ, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0, `MEM_CODE_READ);
        // Unsigned / signed half loads
        do_op("ld_h_u", 32'h1002, 32'h0, 1'b0, `MEM_COUNT_HALF, 1'b1,
              `MEM_CODE_READ, 32'h0000_8001, 32'h0000_8001, 1'b0, `MEM_CODE_READ);
        do_op("ld_h_s", 32'h1002, 32'h0, 1'b0, `MEM_COUNT_HALF, 1'b0,
              `MEM_CODE_READ, 32'h0000_8001, 32'hFFFF_8001, 1'b0, `MEM_CODE_READ);
        // Upper garbage bits are dropped for byte loads
        do_op("ld_b_u", 32'h1003, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b1,
              `MEM_CODE_READ, 32'h1234_5680, 32'h0000_0080, 1'b0, `MEM_CODE_READ);
        // Word load ignores unsigned
        do_op("ld_w", 32'h1008, 32'h0, 1'b0, `MEM_COUNT_WORD, 1'b1,
              `MEM_CODE_READ, 32'h8000_0001, 32'h8000_0001, 1'b0, `MEM_CODE_READ);
        // Word store
        do_op("st_w", 32'h1004, 32'hDEAD_BEEF, 1'b1, `MEM_COUNT_WORD, 1'b0,
              `MEM_CODE_WRITE, 32'hFFFF_FFFF, 32'h0, 1'b0, `MEM_CODE_WRITE);
        // Misaligned word load
        do_op("ld_mis", 32'h1002, 32'h0, 1'b0, `MEM_COUNT_WORD, 1'b0,
              `MEM_CODE_MISALIGNED, 32'hCAFE_F00D, 32'h0, 1'b1, `MEM_CODE_MISALIGNED);
        // Load answered with WRITE is a mismatch
        do_op("ld_mm", 32'h1010, 32'h0, 1'b0, `MEM_COUNT_WORD, 1'b0,
              `MEM_CODE_WRITE, 32'h1111_2222, 32'h0, 1'b1, `MEM_CODE_WRITE);
        // Store out of bounds
        do_op("st_oob", 32'hF000, 32'h55, 1'b1, `MEM_COUNT_BYTE, 1'b0,
              `MEM_CODE_OUT_OF_BOUNDS, 32'h0, 32'h0, 1'b1, `MEM_CODE_OUT_OF_BOUNDS);

        // Silent peripheral: response during REQ must be ignored, then timeout
        i_valid = 1'b1; i_addr = 32'h2000; i_wr_en = 1'b0;
        i_count = `MEM_COUNT_WORD; i_unsigned = 1'b0;
        step();
        i_valid = 1'b0;
        i_res_code = `MEM_CODE_READ;
        chk("to:req_count", o_req_count, `MEM_COUNT_WORD);
        step();
        i_res_code = `MEM_CODE_INVALID;
        chk("to:state_wait", o_dbg_state, 2);
        for (int i = 0; i < T; i++) begin
            chk($sformatf("to:no_done_%0d", i), o_done, 0);
            step();
        end
        chk("to:done", o_done, 1);
        chk("to:err", o_err, 1);
        chk("to:err_code", o_err_code, `MEM_CODE_INVALID);
        chk("to:rd_data", o_rd_data, 0);
        step();
        chk("to:ready", o_ready, 1);

        // Count NONE: immediate error, no request
        i_valid = 1'b1; i_addr = 32'h3000; i_count = `MEM_COUNT_NONE;
        step();
        i_valid = 1'b0;
        chk("none:done", o_done, 1);
        chk("none:req_count", o_req_count, `MEM_COUNT_NONE);
        chk("none:err", o_err, 1);
        chk("none:err_code", o_err_code, `MEM_CODE_INVALID);
        chk("none:ready", o_ready, 0);
        step();
        chk("none:req_count2", o_req_count, `MEM_COUNT_NONE);
        chk("none:ready2", o_ready, 1);

        // Set a non-reset result first so the reset's effect is visible
        do_op("pre_rst", 32'h1001, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b0,
              `MEM_CODE_READ, 32'h0000_0081, 32'hFFFF_FF81, 1'b0, `MEM_CODE_READ);

        // Reset mid-WAIT
        i_valid = 1'b1; i_addr = 32'h4000; i_count = `MEM_COUNT_WORD; i_wr_en = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        chk("rw:in_wait", o_dbg_state, 2);
        aresetn = 1'b0;
        #1;
        chk("rw:req_count", o_req_count, `MEM_COUNT_NONE);
        chk("rw:done", o_done, 0);
        chk("rw:rd_data", o_rd_data, 0);
        chk("rw:err", o_err, 0);
        chk("rw:err_code", o_err_code, `MEM_CODE_INVALID);
        chk("rw:ready", o_ready, 0);
        i_res_code = `MEM_CODE_READ;
        step();
        chk("rw:done2", o_done, 0);
        i_res_code = `MEM_CODE_INVALID;
        aresetn = 1'b1;
        step();
        chk("rw:done3", o_done, 0);
        chk("rw:ready_after", o_ready, 1);
        do_op("post_rst", 32'h1005, 32'h0, 1'b0, `MEM_COUNT_BYTE, 1'b0,
              `MEM_CODE_READ, 32'h0000_007F, 32'h0000_007F, 1'b0, `MEM_CODE_READ);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_load_store_unit.md
Name: mem_load_store_unit

Overview:
- Sits between the core's execute/memory stage and a memory-mapped peripheral port that uses the team's `MEM_COUNT_*` / `MEM_CODE_*` request/response protocol.
- Accepts one load/store at a time and issues a single-cycle request to the peripheral.
- Waits for the registered response, with a bounded timeout.
- Returns sign- or zero-extended load data, plus an error flag and code, to the core.

Parameters:
- TIMEOUT_CYCLES, 8: maximum WAIT cycles without a non-INVALID response before aborting; legal range 1..255.

Ports:
- clk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- i_valid  input  1  core presents an operation
- o_ready  output  1  unit idle and able to accept
- i_addr  input  ADDR_W  byte address
- i_wr_data  input  WORD_W  store data, right-justified
- i_wr_en  input  1  1 = store, 0 = load
- i_count  input  MEM_COUNT_W  access size (`MEM_COUNT_NONE/BYTE/HALF/WORD`)
- i_unsigned  input  1  zero-extend loads when 1
- o_req_addr  output  ADDR_W  peripheral request address
- o_req_wr_data  output  WORD_W  peripheral write data
- o_req_wr_en  output  1  peripheral write enable
- o_req_count  output  MEM_COUNT_W  peripheral request size; NONE when no request
- i_res_rd_data  input  WORD_W  peripheral read data, right-justified, unextended
- i_res_code  input  MEM_CODE_W  peripheral response code
- o_done  output  1  one-cycle completion pulse
- o_rd_data  output  WORD_W  extended load result
- o_err  output  1  completed operation failed
- o_err_code  output  MEM_CODE_W  failing code; INVALID on timeout

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State=IDLE; all registered outputs 0; o_req_count=`MEM_COUNT_NONE`; o_err_code=`MEM_CODE_INVALID`.
  - o_ready is high one cycle after reset deasserts, because it is decoded from IDLE.
- Reset asserted mid-operation discards the operation: no o_done, and request outputs return to NONE immediately.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid, latch addr, wr_data, wr_en, count and unsigned.
  - If i_count==NONE, go to DONE with o_err=1 and o_err_code=INVALID; no peripheral request is made.
  - Otherwise go to REQ.
- REQ, exactly one cycle:
  - o_req_addr, o_req_wr_data, o_req_wr_en and o_req_count driven from the latched values.
  - Timeout counter cleared; next state WAIT.
- WAIT:
  - o_req_count=NONE; request address/data hold their latched values; o_req_wr_en=0.
  - If i_res_code!=INVALID, capture i_res_rd_data and i_res_code, then go to DONE.
  - Otherwise increment the counter; when counter==TIMEOUT_CYCLES-1 with no response, go to DONE with o_err=1 and o_err_code=INVALID.
- DONE, one cycle:
  - o_done=1; o_rd_data, o_err and o_err_code are valid.
  - Next state IDLE.
  - o_rd_data, o_err and o_err_code hold their values until the next DONE.
- Latency:
  - Accept edge at cycle 0, request visible in cycle 1, response in cycle 2, o_done in cycle 3.
  - o_ready is low from cycle 1 until IDLE is re-entered.
  - Back-to-back throughput is one operation per 4 cycles.
- Result rules:
  - Expected code is WRITE for stores and READ for loads.
  - Any other non-INVALID code (MISALIGNED, OUT_OF_BOUNDS, mismatched READ/WRITE) sets o_err=1, o_err_code=received code, o_rd_data=0.
  - Successful store: o_err=0, o_rd_data=0, o_err_code=WRITE.
  - Successful load: o_err=0, o_err_code=READ, and o_rd_data formed as follows:
    - BYTE: bits [7:0], extended from bit 7 unless unsigned.
    - HALF: bits [15:0], extended from bit 15 unless unsigned.
    - WORD: all bits, with i_unsigned ignored.
- No local alignment check: misalignment is reported only through the peripheral's code.
- i_valid outside IDLE is ignored; nothing is queued.
- A response code arriving during IDLE, REQ or DONE is ignored.

Test Plan:
- Signed byte load: addr 0x1001, BYTE, unsigned=0, peripheral returns READ with data 0x000000F0 -> o_done in cycle 3, o_rd_data=0xFFFFFFF0, o_err=0.
- Unsigned half load: addr 0x1002, HALF, unsigned=1, returns READ with 0x00008001 -> o_rd_data=0x00008001. Repeat with unsigned=0 -> o_rd_data=0xFFFF8001.
- Word store: addr 0x1004, data 0xDEADBEEF, WORD -> o_req_count=WORD and o_req_wr_en=1 for exactly one cycle; peripheral returns WRITE -> o_err=0, o_rd_data=0.
- Misaligned word load: addr 0x1002, peripheral returns MISALIGNED -> o_err=1, o_err_code=MISALIGNED, o_rd_data=0.
- Silent peripheral: code held at INVALID -> o_done exactly TIMEOUT_CYCLES cycles after entering WAIT, with o_err=1 and o_err_code=INVALID. Then i_count=NONE -> o_done 1 cycle after accept, o_req_count never leaves NONE.
- Reset mid-WAIT: assert aresetn=0 in WAIT -> no o_done, outputs at reset values. After release, a fresh byte load completes normally.
